hazard_stall_unit: RTL and testbench

//  Consumes the decode-stage control word (RegWrite/MemRead/hazardType/BranchType/NopCheck) produced per stage
//  and enforces pipeline ordering for the 5-stage MIPS core without forwarding: stalls IF/ID on RAW hazards

---
 rtl/hazard_stall_unit_pkg.sv | 26 ++
 rtl/hazard_stall_unit_if.sv | 33 +++
 rtl/hazard_stall_unit_match.sv | 20 ++
 rtl/hazard_stall_unit.sv | 129 ++++++++++++
 tb/tb_hazard_stall_unit.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/hazard_stall_unit_pkg.sv
// Shared encodings for the hazard/stall unit: FSM states, register-zero constant,
// decoder hazardType encodings, and the packed pipeline-control word.
package hazard_stall_unit_pkg;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam logic HZ_RS_RT = 1'b0;
    localparam logic HZ_RS    = 1'b1;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_flush;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE  = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0, idex_flush: 1'b0};
    localparam ctrl_t CTRL_STALL = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0, idex_flush: 1'b1};
    localparam ctrl_t CTRL_FLUSH = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1, idex_flush: 1'b1};

endpackage

// File: rtl/hazard_stall_unit_if.sv
// Pipeline-side bundle for the hazard/stall unit: decode operands, EX/MEM producers,
// branch resolution in; PC/IF-ID/ID-EX control and event counters out.
interface hazard_stall_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       ID_Rs;
    logic [4:0]       ID_Rt;
    logic             ID_HazardType;
    logic             ID_Nop;
    logic             EX_RegWrite;
    logic [4:0]       EX_WriteReg;
    logic             MEM_RegWrite;
    logic [4:0]       MEM_WriteReg;
    logic             BranchTaken;
    logic             PCWrite;
    logic             IFID_Write;
    logic             IFID_Flush;
    logic             IDEX_Flush;
    logic [CNT_W-1:0] StallCount;
    logic [CNT_W-1:0] FlushCount;

    modport master (
        output ID_Rs, ID_Rt, ID_HazardType, ID_Nop,
        output EX_RegWrite, EX_WriteReg, MEM_RegWrite, MEM_WriteReg, BranchTaken,
        input  PCWrite, IFID_Write, IFID_Flush, IDEX_Flush, StallCount, FlushCount
    );

    modport slave (
        input  ID_Rs, ID_Rt, ID_HazardType, ID_Nop,
        input  EX_RegWrite, EX_WriteReg, MEM_RegWrite, MEM_WriteReg, BranchTaken,
        output PCWrite, IFID_Write, IFID_Flush, IDEX_Flush, StallCount, FlushCount
    );
endinterface

// File: rtl/hazard_stall_unit_match.sv
// RAW comparator between one producer stage and the instruction in ID.
module hazard_match
    import hazard_stall_unit_pkg::*;
(
    input  logic       reg_write_i,
    input  logic [4:0] write_reg_i,
    input  logic [4:0] rs_i,
    input  logic [4:0] rt_i,
    input  logic       hazard_type_i,
    input  logic       nop_i,
    output logic       match_o
);
    logic rs_hit_s;
    logic rt_hit_s;

    assign rs_hit_s = (write_reg_i == rs_i);
    // rt only matters when the decoder says the instruction actually reads it
    assign rt_hit_s = (hazard_type_i == HZ_RS_RT) && (write_reg_i == rt_i);
    assign match_o  = reg_write_i && (write_reg_i != REG_ZERO) && !nop_i && (rs_hit_s || rt_hit_s);
endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/flush controller for the non-forwarding 5-stage pipeline, with stall and
// taken-branch flush event counters.
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int EX_STALL  = 2,
    parameter int MEM_STALL = 1,
    parameter int CNT_W     = 32
) (
    input logic         Clk,
    input logic         Rst,
    hazard_stall_if.slave hz
);
    localparam logic [1:0] EX_N  = 2'(EX_STALL);
    localparam logic [1:0] MEM_N = 2'(MEM_STALL);

    logic             ex_match_s;
    logic             mem_match_s;
    logic [1:0]       need_n_s;
    ctrl_t            ctrl_s;
    state_e           state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    hazard_match u_ex_match (
        .reg_write_i   (hz.EX_RegWrite),
        .write_reg_i   (hz.EX_WriteReg),
        .rs_i          (hz.ID_Rs),
        .rt_i          (hz.ID_Rt),
        .hazard_type_i (hz.ID_HazardType),
        .nop_i         (hz.ID_Nop),
        .match_o       (ex_match_s)
    );

    hazard_match u_mem_match (
        .reg_write_i   (hz.MEM_RegWrite),
        .write_reg_i   (hz.MEM_WriteReg),
        .rs_i          (hz.ID_Rs),
        .rt_i          (hz.ID_Rt),
        .hazard_type_i (hz.ID_HazardType),
        .nop_i         (hz.ID_Nop),
        .match_o       (mem_match_s)
    );

    // Required stall length; the EX producer is further from writeback so it wins
    always_comb begin
        need_n_s = 2'd0;
        if (ex_match_s) begin
            need_n_s = EX_N;
        end else if (mem_match_s) begin
            need_n_s = MEM_N;
        end else begin
            need_n_s = 2'd0;
        end
    end

    // Zero-latency control outputs and next-state/counter values
    always_comb begin
        ctrl_s      = CTRL_IDLE;
        state_d     = state_q;
        cnt_d       = cnt_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (Rst) begin
            ctrl_s = CTRL_IDLE;
        end else if (hz.BranchTaken) begin
            ctrl_s      = CTRL_FLUSH;
            state_d     = ST_RUN;
            cnt_d       = 2'd0;
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end else begin
            case (state_q)
                ST_STALL: begin
                    // ID is frozen here, so hazard inputs are deliberately not consulted
                    ctrl_s      = CTRL_STALL;
                    stall_cnt_d = stall_cnt_q + CNT_W'(1);
                    if (cnt_q <= 2'd1) begin
                        state_d = ST_RUN;
                        cnt_d   = 2'd0;
                    end else begin
                        cnt_d = cnt_q - 2'd1;
                    end
                end
                ST_RUN: begin
                    if (need_n_s != 2'd0) begin
                        ctrl_s      = CTRL_STALL;
                        stall_cnt_d = stall_cnt_q + CNT_W'(1);
                        if (need_n_s > 2'd1) begin
                            state_d = ST_STALL;
                            cnt_d   = need_n_s - 2'd1;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        ctrl_s = CTRL_IDLE;
                    end
                end
                default: begin
                    ctrl_s  = CTRL_IDLE;
                    state_d = ST_RUN;
                    cnt_d   = 2'd0;
                end
            endcase
        end
    end

    // FSM state and event counters
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q     <= ST_RUN;
            cnt_q       <= 2'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.PCWrite    = ctrl_s.pc_write;
    assign hz.IFID_Write = ctrl_s.ifid_write;
    assign hz.IFID_Flush = ctrl_s.ifid_flush;
    assign hz.IDEX_Flush = ctrl_s.idex_flush;
    assign hz.StallCount = stall_cnt_q;
    assign hz.FlushCount = flush_cnt_q;
endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit (CNT_W=4 build so counter wrap is reachable).
module tb_hazard_stall_unit;
    localparam int CNT_W = 4;
    localparam logic [3:0] C_IDLE  = 4'b1100;
    localparam logic [3:0] C_STALL = 4'b0001;
    localparam logic [3:0] C_FLUSH = 4'b1111;

    logic clk;
    logic rst;
    int   checks_cnt;
    int   errors_cnt;
    logic [3:0] ctrl_s;

    hazard_stall_if #(.CNT_W(CNT_W)) hz ();

    hazard_stall_unit #(.EX_STALL(2), .MEM_STALL(1), .CNT_W(CNT_W)) dut (
        .Clk (clk),
        .Rst (rst),
        .hz  (hz.slave)
    );

    assign ctrl_s = {hz.PCWrite, hz.IFID_Write, hz.IFID_Flush, hz.IDEX_Flush};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_in();
        hz.ID_Rs = 5'd0; hz.ID_Rt = 5'd0; hz.ID_HazardType = 1'b0; hz.ID_Nop = 1'b0;
        hz.EX_RegWrite = 1'b0; hz.EX_WriteReg = 5'd0;
        hz.MEM_RegWrite = 1'b0; hz.MEM_WriteReg = 5'd0;
        hz.BranchTaken = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic ex_prod(input logic [4:0] rd);
        hz.EX_RegWrite = 1'b1; hz.EX_WriteReg = rd;
    endtask

    initial begin
        checks_cnt = 0;
        errors_cnt = 0;
        clear_in();
        rst = 1'b1;
        // Hazard and branch asserted under reset must still give idle outputs
        ex_prod(5'd3); hz.ID_Rs = 5'd3; hz.BranchTaken = 1'b1;
        #12;
        check_val("rst_ctrl", 32'(ctrl_s), 32'(C_IDLE));
        check_val("rst_stall_cnt", 32'(hz.StallCount), 32'd0);
        check_val("rst_flush_cnt", 32'(hz.FlushCount), 32'd0);
        clear_in();
        @(negedge clk); rst = 1'b0;
        tick();

        // EX producer $3, ID reads rs=3: two stall cycles
        ex_prod(5'd3); hz.ID_Rs = 5'd3; #1;
        check_val("ex_stall_c1", 32'(ctrl_s), 32'(C_STALL));
        tick();
        hz.EX_RegWrite = 1'b0; hz.MEM_RegWrite = 1'b1; hz.MEM_WriteReg = 5'd3; #1;
        check_val("ex_stall_c2", 32'(ctrl_s), 32'(C_STALL));
        tick();
        clear_in(); hz.ID_Rs = 5'd3; #1;
        check_val("ex_after", 32'(ctrl_s), 32'(C_IDLE));
        check_val("ex_stall_cnt", 32'(hz.StallCount), 32'd2);

        // MEM producer $5, ID reads rt=5 (rs,rt type): one stall cycle
        clear_in();
        hz.MEM_RegWrite = 1'b1; hz.MEM_WriteReg = 5'd5; hz.ID_Rs = 5'd1; hz.ID_Rt = 5'd5; #1;
        check_val("mem_rt_stall", 32'(ctrl_s), 32'(C_STALL));
        tick();
        clear_in(); hz.ID_Rs = 5'd1; hz.ID_Rt = 5'd5; #1;
        check_val("mem_rt_after", 32'(ctrl_s), 32'(C_IDLE));
        check_val("mem_stall_cnt", 32'(hz.StallCount), 32'd3);
        // Same operands but rs-only instruction: no stall
        hz.MEM_RegWrite = 1'b1; hz.MEM_WriteReg = 5'd5; hz.ID_HazardType = 1'b1; #1;
        check_val("mem_rs_only", 32'(ctrl_s), 32'(C_IDLE));
        tick();

        // $0 destination and nop in ID never stall
        clear_in(); ex_prod(5'd0); hz.ID_Rs = 5'd0; #1;
        check_val("reg_zero", 32'(ctrl_s), 32'(C_IDLE));
        tick();
        clear_in(); ex_prod(5'd7); hz.ID_Rs = 5'd7; hz.ID_Nop = 1'b1; #1;
        check_val("id_nop", 32'(ctrl_s), 32'(C_IDLE));
        tick();
        check_val("noh_stall_cnt", 32'(hz.StallCount), 32'd3);
        check_val("noh_flush_cnt", 32'(hz.FlushCount), 32'd0);

        // EX and MEM both match: EX length wins, 2nd cycle stalls with inputs cleared
        clear_in(); ex_prod(5'd4); hz.MEM_RegWrite = 1'b1; hz.MEM_WriteReg = 5'd4; hz.ID_Rt = 5'd4; #1;
        check_val("both_c1", 32'(ctrl_s), 32'(C_STALL));
        tick();
        clear_in(); #1;
        check_val("both_c2", 32'(ctrl_s), 32'(C_STALL));
        tick();
        check_val("both_after", 32'(ctrl_s), 32'(C_IDLE));
        check_val("both_stall_cnt", 32'(hz.StallCount), 32'd5);

        // Taken branch in the 2nd stall cycle overrides the stall
        ex_prod(5'd3); hz.ID_Rs = 5'd3; #1;
        check_val("br_c1", 32'(ctrl_s), 32'(C_STALL));
        tick();
        clear_in(); hz.BranchTaken = 1'b1; #1;
        check_val("br_flush", 32'(ctrl_s), 32'(C_FLUSH));
        tick();
        clear_in(); #1;
        check_val("br_run", 32'(ctrl_s), 32'(C_IDLE));
        check_val("br_stall_cnt", 32'(hz.StallCount), 32'd6);
        check_val("br_flush_cnt", 32'(hz.FlushCount), 32'd1);

        // Reset in the middle of a stall
        ex_prod(5'd9); hz.ID_Rs = 5'd9; #1;
        check_val("rs_c1", 32'(ctrl_s), 32'(C_STALL));
        tick();
        clear_in(); rst = 1'b1; #1;
        check_val("rs_ctrl", 32'(ctrl_s), 32'(C_IDLE));
        check_val("rs_stall_cnt", 32'(hz.StallCount), 32'd0);
        check_val("rs_flush_cnt", 32'(hz.FlushCount), 32'd0);
        tick();
        @(negedge clk); rst = 1'b0;
        tick();
        ex_prod(5'd9); hz.ID_Rs = 5'd9; #1;
        check_val("rs_post_c1", 32'(ctrl_s), 32'(C_STALL));
        tick();
        clear_in(); #1;
        check_val("rs_post_c2", 32'(ctrl_s), 32'(C_STALL));
        tick();
        check_val("rs_post_idle", 32'(ctrl_s), 32'(C_IDLE));
        check_val("rs_post_cnt", 32'(hz.StallCount), 32'd2);

        // Counter wrap: 14 more single-cycle MEM stalls take StallCount 2 -> 16 = 0
        hz.MEM_RegWrite = 1'b1; hz.MEM_WriteReg = 5'd6; hz.ID_Rs = 5'd6;
        for (int i = 0; i < 14; i++) tick();
        clear_in(); #1;
        check_val("stall_wrap", 32'(hz.StallCount), 32'd0);
        hz.BranchTaken = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        check_val("flush_15", 32'(hz.FlushCount), 32'd15);
        tick();
        check_val("flush_wrap", 32'(hz.FlushCount), 32'd0);
        clear_in();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end
endmodule
